// File: rtl/head_seek_ctrl_pkg.sv
// Shared types and constants for the head seek controller: FSM states, coil phases
// and the phase rotation helper.
package head_seek_ctrl_pkg;

  localparam int unsigned COIL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STEP_WAIT  = 2'd1,
    ST_SETTLE     = 2'd2,
    ST_RECAL_WAIT = 2'd3
  } seek_state_e;

  localparam logic [COIL_W-1:0] PH_0 = 4'b0001;
  localparam logic [COIL_W-1:0] PH_1 = 4'b0010;
  localparam logic [COIL_W-1:0] PH_2 = 4'b0100;
  localparam logic [COIL_W-1:0] PH_3 = 4'b1000;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Next coil phase; any corrupted (non-one-hot) pattern recovers to PH_0.
  function automatic logic [COIL_W-1:0] rotate_phase(input logic [COIL_W-1:0] cur,
                                                     input logic dir);
    case (cur)
      PH_0:    rotate_phase = (dir == DIR_IN) ? PH_1 : PH_3;
      PH_1:    rotate_phase = (dir == DIR_IN) ? PH_2 : PH_0;
      PH_2:    rotate_phase = (dir == DIR_IN) ? PH_3 : PH_1;
      PH_3:    rotate_phase = (dir == DIR_IN) ? PH_0 : PH_2;
      default: rotate_phase = PH_0;
    endcase
  endfunction

endpackage

// File: rtl/head_seek_ctrl_phase_gen.sv
// Stepper coil phase register: one-hot coil drive advanced one phase per request.
module head_seek_ctrl_phase_gen
  import head_seek_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              dir,
  output logic [COIL_W-1:0] coil
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coil <= PH_0;
    end else if (advance) begin
      coil <= rotate_phase(coil, dir);
    end
  end

endmodule

// File: rtl/head_seek_ctrl.sv
// Floppy head positioning: tracks host STEP/DIR into a target cylinder and walks the
// stepper toward it at a safe rate, with settle time and track-00 recalibration.
module head_seek_ctrl
  import head_seek_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES   = 150000,
  parameter int unsigned SETTLE_CYCLES = 750000,
  parameter int unsigned MAX_TRACK     = 79,
  parameter int unsigned TRACK_W       = 7,
  parameter int unsigned RECAL_MARGIN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_n,
  input  logic               dir_sel,
  input  logic               recal,
  input  logic               t00_sens,
  output logic [COIL_W-1:0]  coil,
  output logic [TRACK_W-1:0] track,
  output logic               track0_n,
  output logic               busy,
  output logic               seek_done,
  output logic               pos_valid,
  output logic               recal_err
);

  localparam int unsigned TIMER_MAX   = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TIMER_W     = $clog2(TIMER_MAX);
  localparam int unsigned RECAL_LIMIT = MAX_TRACK + RECAL_MARGIN;
  localparam int unsigned RCNT_W      = $clog2(RECAL_LIMIT + 1);

  seek_state_e        state;
  logic               step_s1, step_s2, step_s3;
  logic               dir_s1, dir_s2;
  logic               t00_s1, t00_s2;
  logic [TRACK_W-1:0] target;
  logic [TIMER_W-1:0] timer;
  logic [RCNT_W-1:0]  rcount;
  logic               recal_pend;

  logic               step_fall_c, can_inc_c, can_dec_c, accept_c;
  logic [TRACK_W-1:0] target_eff_c;
  logic               step_done_c, settle_done_c, recal_go_c;
  logic               seek_move_c, recal_move_c, move_dir_c;

  // Step acceptance and phase-issue decisions; the coil and the FSM act on these together.
  always_comb begin
    step_fall_c   = step_s3 & ~step_s2;
    can_inc_c     = (dir_s2 == DIR_IN) && (target < TRACK_W'(MAX_TRACK));
    can_dec_c     = (dir_s2 == DIR_OUT) && (target != '0);
    accept_c      = step_fall_c && (state != ST_RECAL_WAIT) && (can_inc_c || can_dec_c);
    target_eff_c  = target;
    if (accept_c) begin
      target_eff_c = can_inc_c ? target + TRACK_W'(1) : target - TRACK_W'(1);
    end
    step_done_c   = (timer == TIMER_W'(STEP_CYCLES - 1));
    settle_done_c = (timer == TIMER_W'(SETTLE_CYCLES - 1));
    recal_go_c    = recal | recal_pend;
    seek_move_c   = 1'b0;
    recal_move_c  = 1'b0;
    case (state)
      ST_IDLE:       seek_move_c  = !recal_go_c && (target_eff_c != track);
      ST_STEP_WAIT:  seek_move_c  = step_done_c && !recal_go_c && (target_eff_c != track);
      ST_SETTLE:     seek_move_c  = accept_c;
      ST_RECAL_WAIT: recal_move_c = step_done_c && !t00_s2 && (rcount != RCNT_W'(RECAL_LIMIT));
      default:       ;
    endcase
    move_dir_c = recal_move_c ? DIR_OUT : ((target_eff_c > track) ? DIR_IN : DIR_OUT);
  end

  head_seek_ctrl_phase_gen u_phase_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (seek_move_c | recal_move_c),
    .dir     (move_dir_c),
    .coil    (coil)
  );

  // Synchronizers, target tracking and the seek/recalibrate FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1    <= 1'b1;
      step_s2    <= 1'b1;
      step_s3    <= 1'b1;
      dir_s1     <= 1'b0;
      dir_s2     <= 1'b0;
      t00_s1     <= 1'b0;
      t00_s2     <= 1'b0;
      track0_n   <= 1'b1;
      state      <= ST_IDLE;
      track      <= '0;
      target     <= '0;
      timer      <= '0;
      rcount     <= '0;
      recal_pend <= 1'b0;
      busy       <= 1'b0;
      seek_done  <= 1'b0;
      pos_valid  <= 1'b0;
      recal_err  <= 1'b0;
    end else begin
      step_s1   <= step_n;
      step_s2   <= step_s1;
      step_s3   <= step_s2;
      dir_s1    <= dir_sel;
      dir_s2    <= dir_s1;
      t00_s1    <= t00_sens;
      t00_s2    <= t00_s1;
      track0_n  <= ~t00_s1;
      seek_done <= 1'b0;

      if (accept_c) target <= target_eff_c;
      if (recal && (state == ST_STEP_WAIT || state == ST_SETTLE)) recal_pend <= 1'b1;
      if (seek_move_c) track <= (move_dir_c == DIR_IN) ? track + TRACK_W'(1) : track - TRACK_W'(1);

      case (state)
        ST_IDLE: begin
          if (recal_go_c) begin
            recal_pend <= 1'b0;
            if (t00_s2) begin
              track     <= '0;
              target    <= '0;
              pos_valid <= 1'b1;
              recal_err <= 1'b0;
              seek_done <= 1'b1;
            end else begin
              state  <= ST_RECAL_WAIT;
              busy   <= 1'b1;
              timer  <= '0;
              rcount <= '0;
            end
          end else if (seek_move_c) begin
            state <= ST_STEP_WAIT;
            busy  <= 1'b1;
            timer <= '0;
          end
        end

        ST_STEP_WAIT: begin
          if (!step_done_c) begin
            timer <= timer + TIMER_W'(1);
          end else begin
            timer <= '0;
            if (recal_go_c) begin
              state      <= ST_RECAL_WAIT;
              recal_pend <= 1'b0;
              rcount     <= '0;
            end else if (!seek_move_c) begin
              state <= ST_SETTLE;
            end
          end
        end

        // A fresh host step restarts motion at once instead of waiting out the settle.
        ST_SETTLE: begin
          if (seek_move_c) begin
            state <= ST_STEP_WAIT;
            timer <= '0;
          end else if (settle_done_c) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            timer     <= '0;
            seek_done <= 1'b1;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_RECAL_WAIT: begin
          if (!step_done_c) begin
            timer <= timer + TIMER_W'(1);
          end else begin
            timer <= '0;
            if (t00_s2) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              track     <= '0;
              target    <= '0;
              pos_valid <= 1'b1;
              recal_err <= 1'b0;
              seek_done <= 1'b1;
            end else if (rcount == RCNT_W'(RECAL_LIMIT)) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              recal_err <= 1'b1;
            end else begin
              rcount <= rcount + RCNT_W'(1);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
